rv32i_dbus_ctrl: RTL and testbench
==================================

Name: rv32i_dbus_ctrl

Overview:
Multi-cycle data-bus controller between the RV32I core's load/store port and NUM_SLV memory-mapped slaves (data RAM, peripherals). It replaces the direct core-to-data-memory hookup of the single-cycle top. It decodes the address region and generates byte enables and write-data lane replication from funct3. It runs a req/ack handshake with variable-latency slaves, stalls the core until completion, and returns sign/zero-extended load data.

Parameters:
NUM_SLV, 4, number of slave channels (1..16)
SEL_LSB, 12, lowest address bit of the slave-select field
SEL_BITS, 4, width of the slave-select field; index = m_addr[SEL_LSB +: SEL_BITS]
TIMEOUT_CYC, 16, cycles in ACCESS before abort (used only with timeout feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
m_req  in  1  core load/store request; held stable until m_ack
m_we  in  1  1 = store, 0 = load
m_addr  in  32  byte address
m_wdata  in  32  store data (value in low bits)
m_funct3  in  3  store_type/load_type: 000 B, 001 H, 010 W, 100 BU, 101 HU
m_rdata  out  32  extended load data; valid when m_ack
m_ack  out  1  one-cycle completion pulse
m_err  out  1  with m_ack: unmapped, misaligned or timed-out access
m_stall  out  1  = m_req & ~m_ack (combinational)
s_req  out  NUM_SLV  one-hot slave request, registered
s_we  out  1  shared write enable
s_addr  out  32  shared word address (m_addr with [1:0] = 0)
s_wdata  out  32  shared lane-replicated write data
s_be  out  4  shared byte enables
s_rdata  in  32*NUM_SLV  packed slave read data; slave i at [32*i +: 32]
s_ack  in  NUM_SLV  slave completion, sampled only for the addressed slave
dbg_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0: s_req, s_we, s_addr, s_wdata, s_be, m_ack, m_err, m_rdata, dbg_err. Reset mid-ACCESS drops s_req immediately and abandons the transfer.
- FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP on error.
- IDLE, m_req=1: latch addr, we, funct3, wdata and decoded index.
  - Index >= NUM_SLV, or misaligned: go to RESP with err=1; no slave access. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Otherwise go to ACCESS and assert s_req[idx] next cycle.
- ACCESS: s_req[idx] held. On s_ack[idx]=1: capture and extend s_rdata[idx], drop s_req, go to RESP. Acks from other slaves are ignored.
- RESP: m_ack=1 for exactly one cycle, m_err valid, m_rdata valid (0 on error or store). Always returns to IDLE. A new request is accepted no earlier than the cycle after RESP.
- Minimum latency: request seen at cycle 0 -> s_req at cycle 1 (zero-wait ack) -> m_ack at cycle 2.
- Byte enables:
  - B: 0001 << a[1:0]
  - H: 0011 << {a[1],0}
  - W: 1111
  - Loads use the same enables.
- Write data: B = byte replicated x4; H = half replicated x2; W as-is.
- Load extension: select the byte/half by a[1:0]. B/H sign-extend, BU/HU zero-extend, W pass-through.
- Unlisted funct3 values (011, 110, 111): treated as W.
- dbg_err is set on any m_err.

Optional Feature:
Macro DBUS_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and counts each cycle without ack. On reaching TIMEOUT_CYC, s_req drops and the FSM goes to RESP with m_err=1 and m_rdata=0. An ack arriving in that same cycle wins, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package rv32i_dbus_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum typedef (IDLE/ACCESS/RESP), be_gen function.
- One combinational sub-module rv32i_lsu_align: byte enables, write-data replication, load extension.

Test Plan:
- Store W 0xDEADBEEF to 0x0000_1004, slave1 zero-wait -> s_req=0010, s_be=1111, s_addr=0x1004; m_ack at cycle 2, m_err=0.
- Store B 0xA5 to 0x0000_2003, slave2 acks after 5 cycles -> s_be=1000, s_wdata=0xA5A5A5A5; m_stall high 7 cycles; one m_ack pulse.
- Load B at 0x0000_0002, slave0 rdata 0x0080FF00 -> m_rdata=0xFFFFFF80. Load BU at the same address -> 0x00000080. Load HU at 0x0000_0002 -> 0x00000080.
- Load H at 0x0000_0001 -> no s_req; m_ack at cycle 1 with m_err=1; dbg_err=1 stays set. Access to 0x0000_5000 with NUM_SLV=4 -> same error response.
- Slave never acks, DBUS_TIMEOUT_EN, TIMEOUT_CYC=16 -> s_req drops after 16 ACCESS cycles; m_ack with m_err=1, m_rdata=0. Without the macro: still stalled after 100 cycles.
- reset=0 asserted mid-ACCESS -> s_req=0 immediately; after release the next load completes normally.

Source files
------------

// File: rtl/rv32i_dbus_pkg.sv
// rv32i_dbus_pkg: shared types and helpers for the data-bus controller.
// funct3 codes, FSM states, byte-enable and alignment helpers.
package rv32i_dbus_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [3:0] be_gen(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): be = 4'b0001 << off;
      (f3 == F3_H) || (f3 == F3_HU): be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misal(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): m = 1'b0;
      (f3 == F3_H) || (f3 == F3_HU): m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// rv32i_lsu_align: byte enables, store lane replication, load extension.
// Purely combinational; unlisted funct3 values behave as word accesses.
module rv32i_lsu_align
  import rv32i_dbus_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misal
);

  logic [7:0]  b;
  logic [15:0] h;
  logic is_b, is_bu, is_h, is_hu;

  // lane select, replication and sign/zero extension
  always_comb begin
    be        = be_gen(funct3, off);
    misal     = is_misal(funct3, off);
    b         = 8'(rdata >> {off, 3'b000});
    h         = off[1] ? rdata[31:16] : rdata[15:0];
    is_b      = (funct3 == F3_B);
    is_bu     = (funct3 == F3_BU);
    is_h      = (funct3 == F3_H);
    is_hu     = (funct3 == F3_HU);
    wdata_rep = wdata;
    rdata_ext = rdata;
    unique case (1'b1)
      is_b: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{b[7]}}, b};
      end
      is_bu: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, b};
      end
      is_h: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{h[15]}}, h};
      end
      is_hu: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_dbus_ctrl.sv
// rv32i_dbus_ctrl: multi-cycle core data bus, req/ack to NUM_SLV slaves.
// Optional DBUS_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles.
module rv32i_dbus_ctrl
  import rv32i_dbus_pkg::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int SEL_LSB     = 12,
  parameter int SEL_BITS    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [2:0]            m_funct3,
  output logic [31:0]           m_rdata,
  output logic                  m_ack,
  output logic                  m_err,
  output logic                  m_stall,
  output logic [NUM_SLV-1:0]    s_req,
  output logic                  s_we,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_be,
  input  logic [32*NUM_SLV-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_ack,
  output logic                  dbg_err
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rv32i_dbus_ctrl: bad parameters");
  end

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [SEL_BITS-1:0] idx_q, idx_d;
  logic [NUM_SLV-1:0]  sreq_q, sreq_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                dbg_q, dbg_d;

  logic [SEL_BITS-1:0] sel;
  logic                unmapped;
  logic [2:0]          al_f3;
  logic [1:0]          al_off;
  logic [3:0]          al_be;
  logic [31:0]         al_wdata, al_rdata, rdata_sel;
  logic                al_misal;
  logic                ack_sel;

`ifdef DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));
`endif

  assign sel      = m_addr[SEL_LSB +: SEL_BITS];
  assign unmapped = ({{(32-SEL_BITS){1'b0}}, sel} >= 32'(NUM_SLV));
  assign al_f3    = (state_q == IDLE) ? m_funct3 : f3_q;
  assign al_off   = (state_q == IDLE) ? m_addr[1:0] : addr_q[1:0];

  rv32i_lsu_align u_align (
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (m_wdata),
    .rdata     (rdata_sel),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misal     (al_misal)
  );

  // pick ack and read data of the addressed slave only
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        ack_sel   = s_ack[i];
        rdata_sel = s_rdata[32*i +: 32];
      end
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idx_d   = idx_q;
    sreq_d  = sreq_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    dbg_d   = dbg_q;
`ifdef DBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          we_d    = m_we;
          f3_d    = m_funct3;
          wdata_d = al_wdata;
          be_d    = al_be;
          idx_d   = sel;
          rdata_d = '0;
          if (unmapped || al_misal) begin
            err_d   = 1'b1;
            dbg_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
            for (int i = 0; i < NUM_SLV; i++)
              sreq_d[i] = (sel == SEL_BITS'(i));
`ifdef DBUS_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          rdata_d = we_q ? 32'h0 : al_rdata;
          sreq_d  = '0;
          state_d = RESP;
        end else begin
`ifdef DBUS_TIMEOUT_EN
          if (tmo) begin
            sreq_d  = '0;
            err_d   = 1'b1;
            dbg_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      sreq_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      dbg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      sreq_q  <= sreq_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      dbg_q   <= dbg_d;
    end
  end

`ifdef DBUS_TIMEOUT_EN
  // access watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign m_ack   = (state_q == RESP);
  assign m_err   = m_ack & err_q;
  assign m_rdata = m_ack ? rdata_q : 32'h0;
  assign m_stall = m_req & ~m_ack;
  assign s_req   = sreq_q;
  assign s_we    = we_q;
  assign s_addr  = {addr_q[31:2], 2'b00};
  assign s_wdata = wdata_q;
  assign s_be    = be_q;
  assign dbg_err = dbg_q;

endmodule

// File: tb/tb_rv32i_dbus_ctrl.sv
// tb_rv32i_dbus_ctrl: scoreboard bench for rv32i_dbus_ctrl.
// Slave models with programmable latency; responses checked via queue.
module tb_rv32i_dbus_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_req, m_we;
  logic [31:0]  m_addr, m_wdata;
  logic [2:0]   m_funct3;
  logic [31:0]  m_rdata;
  logic         m_ack, m_err, m_stall;
  logic [3:0]   s_req;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_be;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic         dbg_err;

  logic [31:0] srd [4];
  int          lat [4];
  int          scnt [4];

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_tx  = 0;
  int n_ack = 0;

  int          r_lat, r_stall, r_sreq;
  logic [3:0]  c_sreq, c_be;
  logic [31:0] c_addr, c_wd;
  logic        c_we;

  always #5 clk = ~clk;

  assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};

  rv32i_dbus_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_funct3 (m_funct3),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_stall  (m_stall),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_rdata  (s_rdata),
    .s_ack    (s_ack),
    .dbg_err  (dbg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [2:0] f3,
      input logic [1:0] off, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b001:  return 32'($signed(sh[15:0]));
      3'b100:  return sh & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic mdl_err(input logic [2:0] f3,
      input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  // slave models: ack after lat[i] wait cycles, lat >= 255 never acks
  initial begin
    s_ack = '0;
    for (int i = 0; i < 4; i++) scnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (s_req[i] && !s_ack[i]) begin
          if (lat[i] < 255 && scnt[i] >= lat[i]) s_ack[i] = 1'b1;
          else scnt[i]++;
        end else begin
          s_ack[i] = 1'b0;
          scnt[i]  = 0;
        end
      end
    end
  end

  // response monitor pops the scoreboard on every m_ack
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && m_ack === 1'b1) begin
        n_ack++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_rdata", m_rdata, e.rd);
          chk("sb_err", {31'd0, m_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr,
      input logic [31:0] wd, input logic [2:0] f3,
      input logic [31:0] exp_rd, input logic exp_err,
      input int exp_lat, input string tag);
    int n;
    bit seen;
    @(posedge clk);
    #1;
    m_req = 1'b1; m_we = we; m_addr = addr;
    m_wdata = wd; m_funct3 = f3;
    sb.push_back('{exp_rd, exp_err});
    n_tx++;
    n = 0; r_stall = 0; r_sreq = 0; seen = 0;
    c_sreq = '0; c_be = '0; c_addr = '0; c_wd = '0; c_we = 1'b0;
    while (1) begin
      @(negedge clk);
      if (m_stall) r_stall++;
      if (s_req != 0) begin
        r_sreq++;
        if (!seen) begin
          seen = 1; c_sreq = s_req; c_be = s_be;
          c_addr = s_addr; c_wd = s_wdata; c_we = s_we;
        end
      end
      if (m_ack) break;
      n++;
      if (n > 300) begin
        chk({tag, "_ack_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    r_lat = n;
    chk({tag, "_lat"}, r_lat, exp_lat);
    @(posedge clk);
    #1;
    m_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3s [5];
    logic [31:0] a;
    int          ackc;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 4; i++) begin lat[i] = 0; srd[i] = '0; end
    reset = 1'b0; m_req = 0; m_we = 0; m_addr = '0;
    m_wdata = '0; m_funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sreq", {28'd0, s_req}, 32'd0);
    chk("rst_ack_err", {30'd0, m_ack, m_err}, 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_bus", s_addr | s_wdata | {27'd0, s_we, s_be}, 32'd0);
    chk("rst_dbg", {31'd0, dbg_err}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // store word, zero-wait slave 1
    lat[1] = 0;
    do_req(1, 32'h0000_1004, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, 2, "sw");
    chk("sw_sreq", {28'd0, c_sreq}, 32'h2);
    chk("sw_be", {28'd0, c_be}, 32'hF);
    chk("sw_addr", c_addr, 32'h0000_1004);
    chk("sw_wdata", c_wd, 32'hDEAD_BEEF);
    chk("sw_we", {31'd0, c_we}, 32'd1);

    // store byte, slave 2 with five wait cycles
    lat[2] = 5;
    do_req(1, 32'h0000_2003, 32'h0000_00A5, 3'b000, 32'h0, 0, 7, "sb");
    chk("sb_sreq", {28'd0, c_sreq}, 32'h4);
    chk("sb_be", {28'd0, c_be}, 32'h8);
    chk("sb_wdata", c_wd, 32'hA5A5_A5A5);
    chk("sb_addr", c_addr, 32'h0000_2000);
    chk("sb_stall", r_stall, 7);

    // store half to upper lane
    do_req(1, 32'h0000_1002, 32'h1234_BEEF, 3'b001, 32'h0, 0, 2, "sh");
    chk("sh_be", {28'd0, c_be}, 32'hC);
    chk("sh_wdata", c_wd, 32'hBEEF_BEEF);

    // loads from slave 0
    srd[0] = 32'h0080_FF00; lat[0] = 1;
    do_req(0, 32'h0000_0002, 0, 3'b000, 32'hFFFF_FF80, 0, 3, "lb");
    chk("lb_be", {28'd0, c_be}, 32'h4);
    chk("lb_we", {31'd0, c_we}, 32'd0);
    do_req(0, 32'h0000_0002, 0, 3'b100, 32'h0000_0080, 0, 3, "lbu");
    do_req(0, 32'h0000_0002, 0, 3'b101, 32'h0000_0080, 0, 3, "lhu");
    do_req(0, 32'h0000_0000, 0, 3'b001, 32'hFFFF_FF00, 0, 3, "lh0");
    do_req(0, 32'h0000_0000, 0, 3'b010, 32'h0080_FF00, 0, 3, "lw");

    // error responses
    chk("dbg_before_err", {31'd0, dbg_err}, 32'd0);
    do_req(0, 32'h0000_0001, 0, 3'b001, 32'h0, 1, 1, "lh_mis");
    chk("lh_mis_nosreq", r_sreq, 0);
    chk("dbg_set", {31'd0, dbg_err}, 32'd1);
    do_req(0, 32'h0000_5000, 0, 3'b010, 32'h0, 1, 1, "unmapped");
    chk("unmapped_nosreq", r_sreq, 0);
    do_req(1, 32'h0000_1002, 32'h1, 3'b010, 32'h0, 1, 1, "sw_mis");
    do_req(0, 32'h0000_1001, 0, 3'b011, 32'h0, 1, 1, "f3_011_mis");
    srd[1] = 32'hCAFE_F00D;
    do_req(0, 32'h0000_1000, 0, 3'b111, 32'hCAFE_F00D, 0, 2, "f3_111_w");
    chk("dbg_sticky", {31'd0, dbg_err}, 32'd1);

    // model sweep over funct3 and offset on slave 3
    for (int k = 0; k < 5; k++) begin
      for (int o = 0; o < 4; o++) begin
        lat[3] = $urandom_range(0, 3);
        srd[3] = $urandom;
        a = 32'h0000_3000 | o;
        if (mdl_err(f3s[k], 2'(o)))
          do_req(0, a, 0, f3s[k], 32'h0, 1, 1, "sweep");
        else
          do_req(0, a, 0, f3s[k], mdl_load(f3s[k], 2'(o), srd[3]), 0,
                 lat[3] + 2, "sweep");
      end
    end

    // slave 0 never acks
    lat[0] = 255;
`ifdef DBUS_TIMEOUT_EN
    do_req(0, 32'h0000_0000, 0, 3'b010, 32'h0, 1, 17, "tmo");
    chk("tmo_sreq_cyc", r_sreq, 16);
`else
    @(posedge clk);
    #1;
    m_req = 1'b1; m_we = 0; m_addr = 32'h0; m_funct3 = 3'b010;
    ackc = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_ack) ackc++;
    end
    chk("hang_noack", ackc, 0);
    chk("hang_stall", {31'd0, m_stall}, 32'd1);
    chk("hang_sreq", {28'd0, s_req}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("hang_rst_sreq", {28'd0, s_req}, 32'h0);
    m_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
`endif

    // reset asserted in the middle of an access
    lat[0] = 50;
    @(posedge clk);
    #1;
    m_req = 1'b1; m_we = 0; m_addr = 32'h0; m_funct3 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_sreq", {28'd0, s_req}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_sreq", {28'd0, s_req}, 32'h0);
    chk("rst_mid_ack", {31'd0, m_ack}, 32'd0);
    chk("rst_mid_dbg", {31'd0, dbg_err}, 32'd0);
    m_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    lat[0] = 0;
    do_req(0, 32'h0000_0000, 0, 3'b010, 32'h0080_FF00, 0, 2, "post_rst");
    chk("post_rst_dbg", {31'd0, dbg_err}, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("ack_count", n_ack, n_tx);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
